alu_muldiv_sequencer: RTL and testbench

- Multi-cycle controller that executes MIPS MULTU/DIVU by time-sharing the existing 32-bit ALU for 32 iterations: shift-add multiply and restoring divide.
- Owns the ALU operand/control mux while busy and holds the HI/LO result registers.
- Sits beside the single-cycle datapath; the CPU stalls on busy_o and reads hi_o/lo_o for MFHI/MFLO.

---
 rtl/alu_muldiv_sequencer_if.sv | 35 +++
 rtl/alu_muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_sequencer_if
// Description : Request, ALU-share and result bundle between the datapath
//               and the MULTU/DIVU sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_muldiv_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic              op_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [3:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              busy_o;
    logic              done_o;
    logic              dz_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, alu_result_i,
        input  alu_src1_o, alu_src2_o, alu_ctrl_o, busy_o, done_o, dz_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, alu_result_i,
        output alu_src1_o, alu_src2_o, alu_ctrl_o, busy_o, done_o, dz_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_sequencer
// Description : 32-iteration shift-add MULTU / restoring DIVU on a shared ALU.
// Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    alu_muldiv_sequencer_if.slave   bus
);
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] hi_q, lo_q, m_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_q, busy_q, done_q, dz_q;

    logic [DATA_W-1:0] hi_d, lo_d;
    logic [DATA_W-1:0] w_src1, w_src2, w_rs;
    logic [3:0]        w_ctrl;
    logic              w_carry, w_borrow;

    // The ALU has no carry-out, so carry/borrow are rebuilt from operand and result MSBs.
    always_comb begin
        w_src1   = '0;
        w_src2   = '0;
        w_ctrl   = C_ALU_ADD;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
        w_rs     = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == S_RUN) begin
            if (!op_q) begin
                w_src1  = hi_q;
                w_src2  = lo_q[0] ? m_q : '0;
                w_ctrl  = C_ALU_ADD;
                w_carry = (w_src1[DATA_W-1] & w_src2[DATA_W-1])
                        | ((w_src1[DATA_W-1] | w_src2[DATA_W-1]) & ~bus.alu_result_i[DATA_W-1]);
                hi_d    = {w_carry, bus.alu_result_i[DATA_W-1:1]};
                lo_d    = {bus.alu_result_i[0], lo_q[DATA_W-1:1]};
            end else begin
                w_src1   = w_rs;
                w_src2   = m_q;
                w_ctrl   = C_ALU_SUB;
                w_borrow = (~w_src1[DATA_W-1] & w_src2[DATA_W-1])
                         | ((~w_src1[DATA_W-1] | w_src2[DATA_W-1]) & bus.alu_result_i[DATA_W-1]);
                // A set HI MSB means the 33-bit partial remainder always exceeds M.
                if (hi_q[DATA_W-1] | ~w_borrow) begin
                    hi_d = bus.alu_result_i;
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = w_rs;
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        hi_q    <= '0;
                        lo_q    <= bus.op_i ? bus.src1_i : bus.src2_i;
                        m_q     <= bus.op_i ? bus.src2_i : bus.src1_i;
                        cnt_q   <= '0;
                        op_q    <= bus.op_i;
                        dz_q    <= bus.op_i & (bus.src2_i == '0);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_src1_o = w_src1;
    assign bus.alu_src2_o = w_src2;
    assign bus.alu_ctrl_o = w_ctrl;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.dz_o       = dz_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_sequencer
// Description : Directed self-checking bench with a behavioural 32-bit ALU.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_muldiv_sequencer_if #(.DATA_W(32)) bus ();

    alu_muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: combinational ADD/SUB return path.
    assign bus.alu_result_i = (bus.alu_ctrl_o == 4'b0110) ? (bus.alu_src1_o - bus.alu_src2_o)
                                                         : (bus.alu_src1_o + bus.alu_src2_o);

    // Starts an operation; c counts cycles after the accepting edge (c=1 is N+1).
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output int done_at);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.src1_i = a; bus.src2_i = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        busy_cycles = 0; done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (bus.busy_o) busy_cycles++;
            if (bus.done_o) done_at = c;
        end
    endtask

    task automatic test_reset();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
        total++; if (bus.dz_o !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", bus.dz_o); end
        total++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin bad++;
            $display("FAIL reset_hilo got=%h/%h want=0/0", bus.hi_o, bus.lo_o); end
        total++; if (bus.alu_ctrl_o !== 4'b0010 || bus.alu_src1_o !== 32'h0 || bus.alu_src2_o !== 32'h0) begin bad++;
            $display("FAIL reset_alu got=%b %h %h want=0010 0 0", bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o); end
    endtask

    task automatic test_multu();
        int bc, da;
        do_op(1'b0, 32'd7, 32'd6, bc, da);
        total++; if (da !== 33) begin bad++; $display("FAIL mul7x6_done got=%0d want=33", da); end
        total++; if (bc !== 32) begin bad++; $display("FAIL mul7x6_busy got=%0d want=32", bc); end
        total++; if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd42) begin bad++;
            $display("FAIL mul7x6 got=%h/%h want=0/2a", bus.hi_o, bus.lo_o); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL mul_done_busy got=%b want=0", bus.busy_o); end
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, da);
        total++; if (da !== 33) begin bad++; $display("FAIL mulmax_done got=%0d want=33", da); end
        total++; if (bus.hi_o !== 32'hFFFFFFFE || bus.lo_o !== 32'h00000001) begin bad++;
            $display("FAIL mulmax got=%h/%h want=fffffffe/00000001", bus.hi_o, bus.lo_o); end
    endtask

    task automatic test_divu();
        int bc, da;
        do_op(1'b1, 32'd100, 32'd7, bc, da);
        total++; if (da !== 33) begin bad++; $display("FAIL div100_7_done got=%0d want=33", da); end
        total++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin bad++;
            $display("FAIL div100_7 got=hi %h lo %h want=hi 2 lo e", bus.hi_o, bus.lo_o); end
        total++; if (bus.dz_o !== 1'b0) begin bad++; $display("FAIL div100_7_dz got=%b want=0", bus.dz_o); end
        do_op(1'b1, 32'hFFFFFFFF, 32'h80000000, bc, da);
        total++; if (bus.lo_o !== 32'd1 || bus.hi_o !== 32'h7FFFFFFF) begin bad++;
            $display("FAIL divmsb got=hi %h lo %h want=hi 7fffffff lo 1", bus.hi_o, bus.lo_o); end
    endtask

    task automatic test_div_zero();
        int bc, da;
        do_op(1'b1, 32'd5, 32'd0, bc, da);
        total++; if (bus.lo_o !== 32'hFFFFFFFF || bus.hi_o !== 32'd5) begin bad++;
            $display("FAIL div5_0 got=hi %h lo %h want=hi 5 lo ffffffff", bus.hi_o, bus.lo_o); end
        total++; if (bus.dz_o !== 1'b1) begin bad++; $display("FAIL div5_0_dz got=%b want=1", bus.dz_o); end
        @(negedge clk);
        total++; if (bus.dz_o !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", bus.dz_o); end
        do_op(1'b0, 32'd2, 32'd3, bc, da);
        total++; if (bus.dz_o !== 1'b0 || bus.lo_o !== 32'd6 || bus.hi_o !== 32'd0) begin bad++;
            $display("FAIL mul2x3_after_dz got=dz %b hi %h lo %h want=dz 0 hi 0 lo 6", bus.dz_o, bus.hi_o, bus.lo_o); end
    endtask

    task automatic test_back_to_back();
        int da = -1;
        int bc, da2;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 1'b0; bus.src1_i = 32'd3; bus.src2_i = 32'd5;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (bus.done_o && da < 0) da = c;
            if (c == 5) begin
                bus.start_i = 1'b1; bus.op_i = 1'b1; bus.src1_i = 32'd50; bus.src2_i = 32'd5;
            end else if (c == 6) begin
                bus.start_i = 1'b0;
            end else if (c == 33) begin
                bus.start_i = 1'b1; bus.op_i = 1'b0; bus.src1_i = 32'd4; bus.src2_i = 32'd4;
            end else if (c == 34) begin
                total++; if (bus.busy_o !== 1'b0 || bus.lo_o !== 32'd15) begin bad++;
                    $display("FAIL b2b_start_in_done got=busy %b lo %h want=busy 0 lo f", bus.busy_o, bus.lo_o); end
            end
        end
        total++; if (da !== 33) begin bad++; $display("FAIL b2b_first_done got=%0d want=33", da); end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept_after_done got=%b want=1", bus.busy_o); end
        bc = 0; da2 = -1;
        for (int c = 2; c <= 40 && da2 < 0; c++) begin
            @(negedge clk);
            if (bus.done_o) da2 = c;
        end
        total++; if (da2 !== 33 || bus.lo_o !== 32'd16) begin bad++;
            $display("FAIL b2b_second got=done %0d lo %h want=done 33 lo 10", da2, bus.lo_o); end
    endtask

    task automatic test_reset_mid_run();
        int saw_done = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 1'b0; bus.src1_i = 32'hFFFF; bus.src2_i = 32'hFFFF;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", bus.busy_o); end
        rst = 1'b1; #1;
        total++; if (bus.busy_o !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin bad++;
            $display("FAIL rst_mid_run got=busy %b hi %h lo %h want=0 0 0", bus.busy_o, bus.hi_o, bus.lo_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) saw_done++;
        end
        total++; if (saw_done !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", saw_done); end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.op_i = 1'b0; bus.src1_i = '0; bus.src2_i = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_multu();
        test_divu();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
